// File: rtl/mul_pkg.sv
// Constants and types shared across the multiplier datapath (compression tree,
// final adder and consumer).
package mul_pkg;

    localparam int PROD_W   = 32;
    localparam int SPLIT_LO = 16;

    typedef struct packed {
        logic [PROD_W-1:0] sum;
        logic [PROD_W-1:0] carry;
    } csa_pair_t;

endpackage

// File: rtl/csa_final_adder_pipe_if.sv
// Handshake bundle between the compression tree, the final adder and the product consumer.
// The master side drives the carry-save pair and out_ready; the slave side is the final adder.
interface csa_final_adder_pipe_if
    import mul_pkg::*;
#(
    parameter int W = PROD_W
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] sum_vec;
    logic [W-1:0] carry_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] product;
    logic         overflow;

    modport master (
        output in_valid, sum_vec, carry_vec, out_ready,
        input  in_ready, out_valid, product, overflow
    );

    modport slave (
        input  in_valid, sum_vec, carry_vec, out_ready,
        output in_ready, out_valid, product, overflow
    );
endinterface

// File: rtl/cpa_slice.sv
// N-bit ripple carry-propagate adder: a chain of full-adder cells with carry in and out.
module cpa_slice #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [N:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fa
            assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = c[N];
endmodule

// File: rtl/csa_final_adder_pipe.sv
// Two-stage carry-propagate adder resolving the carry-save pair into the product:
// stage 1 adds the lower LO bits, stage 2 adds the upper bits plus the mid carry.
module csa_final_adder_pipe
    import mul_pkg::*;
#(
    parameter int W  = PROD_W,
    parameter int LO = SPLIT_LO
) (
    input  logic                   clk,
    input  logic                   rst,
    csa_final_adder_pipe_if.slave  bus
);
    localparam int HI = W - LO;

    logic          v1_q, v1_d;
    logic [LO-1:0] lo_q, lo_d;
    logic          c_mid_q, c_mid_d;
    logic [HI-1:0] s_hi_q, s_hi_d;
    logic [HI-1:0] c_hi_q, c_hi_d;
    logic          v2_q, v2_d;
    logic [W-1:0]  product_q, product_d;
    logic          overflow_q, overflow_d;

    logic          ready1, ready2, take_in, advance;
    logic [LO-1:0] lo_sum;
    logic          lo_cout;
    logic [HI-1:0] hi_sum;
    logic          hi_cout;

    cpa_slice #(.N(LO)) u_cpa_lo (
        .a    (bus.sum_vec[LO-1:0]),
        .b    (bus.carry_vec[LO-1:0]),
        .cin  (1'b0),
        .s    (lo_sum),
        .cout (lo_cout)
    );

    cpa_slice #(.N(HI)) u_cpa_hi (
        .a    (s_hi_q),
        .b    (c_hi_q),
        .cin  (c_mid_q),
        .s    (hi_sum),
        .cout (hi_cout)
    );

    // in_ready looks through both stages to out_ready so a full pipe can still stream.
    always_comb begin
        ready2  = !v2_q || bus.out_ready;
        ready1  = !v1_q || ready2;
        take_in = bus.in_valid && ready1;
        advance = v1_q && ready2;

        v1_d       = v1_q;
        lo_d       = lo_q;
        c_mid_d    = c_mid_q;
        s_hi_d     = s_hi_q;
        c_hi_d     = c_hi_q;
        v2_d       = v2_q;
        product_d  = product_q;
        overflow_d = overflow_q;

        if (take_in) begin
            v1_d    = 1'b1;
            lo_d    = lo_sum;
            c_mid_d = lo_cout;
            s_hi_d  = bus.sum_vec[W-1:LO];
            c_hi_d  = bus.carry_vec[W-1:LO];
        end else if (advance) begin
            v1_d = 1'b0;
        end

        if (advance) begin
            v2_d       = 1'b1;
            product_d  = {hi_sum, lo_q};
            overflow_d = hi_cout;
        end else if (v2_q && bus.out_ready) begin
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q       <= 1'b0;
            lo_q       <= '0;
            c_mid_q    <= 1'b0;
            s_hi_q     <= '0;
            c_hi_q     <= '0;
            v2_q       <= 1'b0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            v1_q       <= v1_d;
            lo_q       <= lo_d;
            c_mid_q    <= c_mid_d;
            s_hi_q     <= s_hi_d;
            c_hi_q     <= c_hi_d;
            v2_q       <= v2_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.in_ready  = ready1;
    assign bus.out_valid = v2_q;
    assign bus.product   = product_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: doc/csa_final_adder_pipe.md
Name: csa_final_adder_pipe

Overview:
Downstream neighbour of the half/full-adder compression tree in the high-speed multiplier. It accepts the carry-save pair (sum vector, carry vector) that the tree produces and performs the final carry-propagate addition in two pipeline stages, lower half first and upper half second, to produce the product. Valid/ready handshakes on input and output let the tree and the consumer stall independently.

Parameters:
W, 32, width of the sum/carry vectors and of the product (16x16 multiplier).
LO, 16, width of the lower slice added in stage 1; the upper slice is W-LO bits. Legal range: 1 <= LO < W.

Ports:
clk  input  1  single system clock; all registers update on its rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  sum_vec/carry_vec are valid this cycle.
in_ready  output  1  block accepts this cycle; a transfer occurs when in_valid && in_ready.
sum_vec  input  W  sum vector from the tree; bit i has weight 2^i.
carry_vec  input  W  carry vector from the tree; already aligned, so bit i has weight 2^i.
out_valid  output  1  product/overflow are valid.
out_ready  input  1  consumer accepts; a transfer occurs when out_valid && out_ready.
product  output  W  (sum_vec + carry_vec) mod 2^W.
overflow  output  1  carry out of bit W-1.

Behaviour:
- Reset (asynchronous, takes effect immediately on rst rising):
  - v1 = v2 = 0, so out_valid = 0.
  - product = 0, overflow = 0.
  - All stage data registers = 0.
  - in_ready = 1 while rst is high and after reset.
- Stage 1 register, loaded on input transfer:
  - lo = sum_vec[LO-1:0] + carry_vec[LO-1:0]; store lo[LO-1:0] and c_mid = carry out of bit LO-1.
  - Store s_hi = sum_vec[W-1:LO] and c_hi = carry_vec[W-1:LO].
  - Set v1.
- Stage 2 register, loaded when v1 && ready2:
  - hi = s_hi + c_hi + c_mid, computed at (W-LO+1) bits.
  - product = {hi[W-LO-1:0], lo}; overflow = hi[W-LO].
  - Set v2.
- Flow control:
  - ready2 = !v2 || out_ready.
  - ready1 = !v1 || ready2.
  - in_ready = ready1. This is combinational from out_ready; that path is permitted.
- A stage whose data has moved on and which is not reloaded in the same cycle clears its valid bit.
- Latency: an input accepted in cycle N appears on the outputs (out_valid = 1) in cycle N+2 when there is no backpressure.
- Throughput: one result per cycle when out_ready is held at 1.
- Stall rule: while out_valid && !out_ready, product and overflow are held bit-stable.
- Full pipe (v1 = v2 = 1, out_ready = 0): in_ready = 0 and no data is lost or overwritten.
- Full pipe with out_ready = 1: in_ready = 1. Stage 2 drains, stage 1 shifts into stage 2, and stage 1 loads the new input in the same cycle.
- Ordering: results leave in strict acceptance order.
- Input values are sampled only on transfer; sum_vec/carry_vec are don't-care when in_valid = 0.
- Reset mid-operation: in-flight results are discarded, not replayed, and out_valid drops asynchronously.
- The adder is unsigned and modulo 2^W. Sign interpretation belongs to the upstream partial-product stage.

Decomposition:
- Shared package mul_pkg holds:
  - the constants PROD_W = 32 and SPLIT_LO = 16, used as the defaults of W and LO;
  - a packed typedef csa_pair_t {sum, carry}, shared with the compression tree.
- One sub-module: cpa_slice. It is a parameterised N-bit ripple carry-propagate adder with cin and cout, built from the existing half_adder/full-adder cells.
  - Stage 1 instantiates it with N = LO and cin = 0.
  - Stage 2 instantiates it with N = W-LO and cin = c_mid.
- Pipeline registers and handshake logic stay in the top module.

Test Plan:
- Basic add: sum = 0x000000FF, carry = 0x00000001, accepted in cycle N, out_ready = 1 -> cycle N+2: out_valid = 1, product = 0x00000100, overflow = 0.
- Mid-boundary carry: sum = 0x0000FFFF, carry = 0x00000001 -> product = 0x00010000, overflow = 0. This proves c_mid propagates from stage 1 to stage 2.
- Overflow: sum = 0xFFFFFFFF, carry = 0x00000001 -> product = 0x00000000, overflow = 1. Then sum = 0x80000000, carry = 0x80000000 -> product = 0, overflow = 1.
- Back-to-back: three inputs on consecutive cycles, (1,2), (3,4), (0x1234,0x1111), with out_ready = 1 -> outputs 3, 7, 0x2345 on three consecutive cycles. in_ready stays 1 throughout.
- Backpressure:
  - Hold out_ready = 0 and offer inputs (5,5), (6,6), (7,7) continuously.
  - Required: only the first two are accepted; in_ready = 0 thereafter; product holds 10.
  - Raise out_ready -> outputs 10, 12, 14 in order; (7,7) is accepted on the cycle the pipe advances.
- Reset mid-operation: with v1 = v2 = 1, pulse rst asynchronously between clock edges -> out_valid = 0, product = 0 and overflow = 0 before the next edge. in_ready = 1 after reset, and no stale result is emitted later.
